membus_core_responder: RTL and testbench
========================================

// Module: membus_core_responder
// PURPOSE
//  Memory-bus responder: behavioural 36-bit core memory answering processor cycles
//  (read, write, read-pause-write) on the memory bus. The APR is the initiator; this
//  block is the far end, with delay timing and console single-step/restart switches.
//  Bench and system top instantiate it as an alternative memory bank.
// PARAMETERS
//  ADDR_W    14  word-address width; bank holds 2**ADDR_W 36-bit words
//  ACK_DLY   2   clocks from accepted request to addr_ack pulse (>=1)
//  RD_DLY    3   clocks from addr_ack to rd_rs pulse (>=1)
//  WR_DLY    2   clocks from wr_rs to write completion (>=1)
// PORTS
//  clk             in   1       system clock
//  reset           in   1       asynchronous, active-high
//  rq_cyc          in   1       request cycle; level, held by initiator for whole cycle
//  rd_rq           in   1       read requested (sampled with rq_cyc)
//  wr_rq           in   1       write requested (sampled with rq_cyc)
//  sel             in   1       this bank selected
//  ma              in   ADDR_W  word address, stable while rq_cyc
//  mb_in           in   36      write data, valid on wr_rs
//  wr_rs           in   1       write restart, 1-clock pulse from initiator
//  sw_single_step  in   1       console switch: halt after each addr_ack
//  sw_restart      in   1       console switch: level; rising edge releases single-step halt
//  addr_ack        out  1       1-clock pulse: address accepted
//  rd_rs           out  1       1-clock pulse: read restart, mb_out valid this clock
//  mb_out          out  36      read data; 0 except in the rd_rs clock
//  busy            out  1       high from acceptance until return to IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; addr_ack=rd_rs=busy=0; mb_out=0; memory array NOT cleared.
//  Internal array core[0:2**ADDR_W-1]; latch ma, rd_rq, wr_rq at acceptance.
//  IDLE: rq_cyc&sel&(rd_rq|wr_rq) -> ACK, busy=1 next clock. rq_cyc with neither rq: ignored.
//  ACK: count ACK_DLY clocks, then addr_ack=1 for one clock.
//    sw_single_step=1 at that clock -> STOP, else rd -> RD, write-only -> PAUSE.
//  STOP: hold until sw_restart 0->1 edge (synchronised), then continue as above.
//  RD: after RD_DLY clocks: rd_rs=1, mb_out=core[ma] for one clock.
//    Read-only: core word retained (restore implicit) -> DONE.
//    rd&wr (read-pause-write): -> PAUSE.
//  PAUSE: wait for wr_rs; on wr_rs latch mb_in -> WR. No timeout.
//  WR: after WR_DLY clocks core[ma]<=latched data -> DONE.
//  DONE: busy=0; wait for rq_cyc=0, then IDLE. Back-to-back requires rq_cyc low >=1 clock.
//  Edge cases:
//   - wr_rs in IDLE/ACK/RD/DONE ignored; only PAUSE consumes it.
//   - rq_cyc dropped before addr_ack: abort to IDLE, no pulses, memory unchanged.
//   - rq_cyc dropped in RD after ack: rd_rs still issued; in PAUSE: abort, word unchanged.
//   - sel ignored after acceptance; ma changes after acceptance ignored (latched).
//   - reset mid-cycle: immediate IDLE; an in-progress write is not committed.
//   - address wraps only by width truncation; no out-of-range detection.
// TESTING
//  1 Preload core[020]=777000777000; read 020 -> addr_ack at +ACK_DLY, rd_rs +RD_DLY later, mb_out=777000777000 one clock, word kept.
//  2 Write 004, wr_rs with mb_in=222333111666 -> core[004]=222333111666 after WR_DLY; rd_rs never pulses.
//  3 Read-pause-write 004 (holding 111), wr_rs data=555 -> mb_out=111 on rd_rs, re-read returns 555.
//  4 sw_single_step=1, read 020 -> addr_ack then stall >=50 clocks with no rd_rs; sw_restart 0->1 -> rd_rs RD_DLY later.
//  5 sel=0 or rd_rq=wr_rq=0 with rq_cyc=1 -> no addr_ack, busy=0 throughout.
//  6 Reset asserted in PAUSE of write 004 -> outputs 0 immediately, core[004] unchanged; next read works normally.

Source files
------------

// File: rtl/membus_core_responder.sv
// Behavioural 36-bit core-memory bank answering read, write and read-pause-write
// cycles on the memory bus, with console single-step halt and restart.
module membus_core_responder #(
    parameter int ADDR_W  = 14,
    parameter int ACK_DLY = 2,
    parameter int RD_DLY  = 3,
    parameter int WR_DLY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq_cyc,
    input  logic              rd_rq,
    input  logic              wr_rq,
    input  logic              sel,
    input  logic [ADDR_W-1:0] ma,
    input  logic [35:0]       mb_in,
    input  logic              wr_rs,
    input  logic              sw_single_step,
    input  logic              sw_restart,
    output logic              addr_ack,
    output logic              rd_rs,
    output logic [35:0]       mb_out,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    // Bus handshake: the initiator holds rq_cyc (with rd_rq/wr_rq/ma) for the whole
    // cycle; we answer with one-clock addr_ack and rd_rs pulses, the initiator answers
    // a pending write with a one-clock wr_rs carrying mb_in, and the next cycle may
    // start only after rq_cyc has been low for at least one clock.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_STOP  = 3'd2,
        S_RD    = 3'd3,
        S_PAUSE = 3'd4,
        S_WR    = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int MAX_DLY = (ACK_DLY > RD_DLY) ? ((ACK_DLY > WR_DLY) ? ACK_DLY : WR_DLY)
                                                : ((RD_DLY > WR_DLY) ? RD_DLY : WR_DLY);
    localparam int CNT_W = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY);

    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_DLY - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_DLY - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_DLY - 1);

    logic [35:0]       core [0:(1<<ADDR_W)-1];
    state_t            state;
    state_t            resume_state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] ma_q;
    logic              rd_q;
    logic              wr_q;
    logic [35:0]       wdata_q;
    logic [2:0]        restart_sync;
    logic              restart_edge;
    logic              mem_we;

    assign fsm_state    = state;
    assign resume_state = rd_q ? S_RD : S_PAUSE;
    assign restart_edge = restart_sync[1] & ~restart_sync[2];
    // The commit is gated by state, so an async reset during WR suppresses it.
    assign mem_we       = (state == S_WR) && (cnt == WR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            restart_sync <= '0;
        end else begin
            restart_sync <= {restart_sync[1:0], sw_restart};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            core[ma_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ma_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            addr_ack <= 1'b0;
            rd_rs    <= 1'b0;
            mb_out   <= '0;
            busy     <= 1'b0;
        end else begin
            addr_ack <= 1'b0;
            rd_rs    <= 1'b0;
            mb_out   <= '0;
            case (state)
                S_IDLE: begin
                    if (rq_cyc && sel && (rd_rq || wr_rq)) begin
                        state <= S_ACK;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        ma_q  <= ma;
                        rd_q  <= rd_rq;
                        wr_q  <= wr_rq;
                    end
                end
                S_ACK: begin
                    if (!rq_cyc) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == ACK_LAST) begin
                        addr_ack <= 1'b1;
                        cnt      <= '0;
                        state    <= sw_single_step ? S_STOP : resume_state;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (restart_edge) begin
                        state <= resume_state;
                        cnt   <= '0;
                    end
                end
                S_RD: begin
                    if (cnt == RD_LAST) begin
                        rd_rs  <= 1'b1;
                        mb_out <= core[ma_q];
                        cnt    <= '0;
                        if (wr_q) begin
                            state <= S_PAUSE;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (!rq_cyc) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wr_rs) begin
                        wdata_q <= mb_in;
                        cnt     <= '0;
                        state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (cnt == WR_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!rq_cyc) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_core_responder.sv
// Bench for membus_core_responder: directed bus scenarios plus randomized traffic,
// checked against an address-indexed memory model and an expected-read queue.
module tb_membus_core_responder;

    localparam int ADDR_W  = 14;
    localparam int ACK_DLY = 2;
    localparam int RD_DLY  = 3;
    localparam int WR_DLY  = 2;

    logic              clk;
    logic              reset;
    logic              rq_cyc;
    logic              rd_rq;
    logic              wr_rq;
    logic              sel;
    logic [ADDR_W-1:0] ma;
    logic [35:0]       mb_in;
    logic              wr_rs;
    logic              sw_single_step;
    logic              sw_restart;
    logic              addr_ack;
    logic              rd_rs;
    logic [35:0]       mb_out;
    logic              busy;
    logic [2:0]        fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mem_m [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] pool [8];

    membus_core_responder #(
        .ADDR_W (ADDR_W),
        .ACK_DLY(ACK_DLY),
        .RD_DLY (RD_DLY),
        .WR_DLY (WR_DLY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rq_cyc        (rq_cyc),
        .rd_rq         (rd_rq),
        .wr_rq         (wr_rq),
        .sel           (sel),
        .ma            (ma),
        .mb_in         (mb_in),
        .wr_rs         (wr_rs),
        .sw_single_step(sw_single_step),
        .sw_restart    (sw_restart),
        .addr_ack      (addr_ack),
        .rd_rs         (rd_rs),
        .mb_out        (mb_out),
        .busy          (busy),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] rand36();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[35:0];
    endfunction

    // driver: one full bus cycle, scoring latencies and read data
    task automatic bus_cycle(input logic [ADDR_W-1:0] a, input bit rd, input bit wr,
                             input logic [35:0] wdata, input bit step);
        int n;
        int ack_at;
        int stray;
        logic [35:0] exp_rd;
        @(negedge clk);
        rq_cyc = 1'b1; sel = 1'b1; rd_rq = rd; wr_rq = wr; ma = a;
        if (rd) exp_q.push_back(mem_m.exists(a) ? mem_m[a] : 36'h0);
        ack_at = -1;
        n = 0;
        while (ack_at < 0 && n < ACK_DLY + 10) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("busy_accept", busy, 1);
                sel = 1'($urandom_range(0, 1));
                ma  = ADDR_W'($urandom());
            end
            if (addr_ack) ack_at = n;
        end
        check("ack_lat", ack_at, ACK_DLY + 1);
        if (ack_at < 0) begin
            rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; sel = 1'b1;
            if (rd) exp_rd = exp_q.pop_front();
            repeat (WR_DLY + RD_DLY + 4) @(negedge clk);
            return;
        end
        if (rd) begin
            if (step) begin
                stray = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (rd_rs) stray++;
                end
                check("step_stall_rs", stray, 0);
                check("step_busy", busy, 1);
                sw_restart = 1'b1;
                n = 0;
                while (!rd_rs && n < RD_DLY + 10) begin
                    @(negedge clk);
                    n++;
                end
                check("step_resume", (n >= RD_DLY + 1 && n <= RD_DLY + 4), 1);
            end else begin
                wr_rs = 1'b1;
                mb_in = rand36();
                n = 0;
                while (!rd_rs && n < RD_DLY + 10) begin
                    @(negedge clk);
                    n++;
                    wr_rs = 1'b0;
                end
                check("rd_lat", n, RD_DLY);
            end
            exp_rd = exp_q.pop_front();
            check("rd_data", mb_out, exp_rd);
            if (!wr) check("busy_rd_end", busy, 0);
            @(negedge clk);
            check("mb_clear", {rd_rs, mb_out}, 0);
            sw_restart = 1'b0;
        end
        if (wr) begin
            stray = 0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (rd_rs) stray++;
            end
            wr_rs = 1'b1;
            mb_in = wdata;
            @(negedge clk);
            wr_rs = 1'b0;
            mb_in = rand36();
            n = 1;
            while (busy && n < WR_DLY + 10) begin
                if (rd_rs) stray++;
                @(negedge clk);
                n++;
            end
            check("wr_lat", n, WR_DLY + 1);
            check("wr_no_rs", stray, 0);
            mem_m[a] = wdata;
            wr_rs = 1'b1;
            mb_in = rand36();
            @(negedge clk);
            wr_rs = 1'b0;
        end
        check("done_quiet", {addr_ack, rd_rs, busy}, 0);
        rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; sel = 1'b1;
        @(negedge clk);
    endtask

    task automatic no_accept(input bit s, input bit r, input bit w);
        int hits;
        @(negedge clk);
        rq_cyc = 1'b1; sel = s; rd_rq = r; wr_rq = w; ma = ADDR_W'($urandom());
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (addr_ack || busy || rd_rs) hits++;
        end
        check("no_accept", hits, 0);
        rq_cyc = 1'b0; sel = 1'b1; rd_rq = 1'b0; wr_rq = 1'b0;
        @(negedge clk);
    endtask

    task automatic abort_early(input logic [ADDR_W-1:0] a);
        int pulses;
        @(negedge clk);
        rq_cyc = 1'b1; sel = 1'b1; rd_rq = 1'b1; wr_rq = 1'b1; ma = a;
        @(negedge clk);
        check("abort_busy", busy, 1);
        rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (addr_ack || rd_rs) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_busy_end", busy, 0);
    endtask

    task automatic abort_pause(input logic [ADDR_W-1:0] a);
        int n;
        @(negedge clk);
        rq_cyc = 1'b1; sel = 1'b1; rd_rq = 1'b0; wr_rq = 1'b1; ma = a;
        n = 0;
        while (!addr_ack && n < ACK_DLY + 10) begin
            @(negedge clk);
            n++;
        end
        check("pause_ack_lat", n, ACK_DLY + 1);
        rq_cyc = 1'b0; wr_rq = 1'b0;
        @(negedge clk);
        wr_rs = 1'b1;
        mb_in = rand36();
        @(negedge clk);
        wr_rs = 1'b0;
        repeat (WR_DLY + 2) @(negedge clk);
        check("pause_abort_busy", busy, 0);
    endtask

    task automatic reset_in_pause(input logic [ADDR_W-1:0] a);
        int n;
        @(negedge clk);
        rq_cyc = 1'b1; sel = 1'b1; rd_rq = 1'b0; wr_rq = 1'b1; ma = a;
        n = 0;
        while (!addr_ack && n < ACK_DLY + 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_ack_lat", n, ACK_DLY + 1);
        #2 reset = 1'b1;
        #1 check("rst_async", {addr_ack, rd_rs, busy, mb_out}, 0);
        @(negedge clk);
        wr_rs = 1'b1;
        mb_in = rand36();
        rq_cyc = 1'b0; wr_rq = 1'b0;
        @(negedge clk);
        wr_rs = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        int op;
        logic [ADDR_W-1:0] a;
        reset = 1'b1; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; sel = 1'b0;
        ma = '0; mb_in = '0; wr_rs = 1'b0; sw_single_step = 1'b0; sw_restart = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_addr_ack", addr_ack, 0);
        check("reset_rd_rs", rd_rs, 0);
        check("reset_mb_out", mb_out, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        bus_cycle(14'o20, 1'b0, 1'b1, 36'o777000777000, 1'b0);
        bus_cycle(14'o4, 1'b0, 1'b1, 36'o222333111666, 1'b0);
        bus_cycle(14'o20, 1'b1, 1'b0, '0, 1'b0);
        bus_cycle(14'o20, 1'b1, 1'b0, '0, 1'b0);
        bus_cycle(14'o4, 1'b1, 1'b0, '0, 1'b0);

        bus_cycle(14'o4, 1'b0, 1'b1, 36'o111, 1'b0);
        bus_cycle(14'o4, 1'b1, 1'b1, 36'o555, 1'b0);
        bus_cycle(14'o4, 1'b1, 1'b0, '0, 1'b0);

        sw_single_step = 1'b1;
        bus_cycle(14'o20, 1'b1, 1'b0, '0, 1'b1);
        sw_single_step = 1'b0;

        no_accept(1'b0, 1'b1, 1'b0);
        no_accept(1'b0, 1'b1, 1'b1);
        no_accept(1'b1, 1'b0, 1'b0);

        @(negedge clk);
        wr_rs = 1'b1;
        mb_in = rand36();
        @(negedge clk);
        wr_rs = 1'b0;

        abort_early(14'o4);
        bus_cycle(14'o4, 1'b1, 1'b0, '0, 1'b0);
        abort_pause(14'o4);
        bus_cycle(14'o4, 1'b1, 1'b0, '0, 1'b0);
        reset_in_pause(14'o4);
        bus_cycle(14'o4, 1'b1, 1'b0, '0, 1'b0);
        bus_cycle(14'o20, 1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            pool[i] = (i == 0) ? {ADDR_W{1'b1}} : ADDR_W'($urandom());
            bus_cycle(pool[i], 1'b0, 1'b1, rand36(), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            a  = pool[$urandom_range(0, 7)];
            case (op)
                0:       bus_cycle(a, 1'b1, 1'b0, '0, 1'b0);
                1:       bus_cycle(a, 1'b0, 1'b1, rand36(), 1'b0);
                default: bus_cycle(a, 1'b1, 1'b1, rand36(), 1'b0);
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            bus_cycle(pool[i], 1'b1, 1'b0, '0, 1'b0);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
